// File: rtl/reg_file_pkg.sv
// reg_file_pkg
//   Shared definitions for the parametrised register file and its scoreboard.
//   - RF_MAX_REGS     : largest supported register count
//   - reg_idx_t       : register-index type wide enough for RF_MAX_REGS entries
//   - rf_reset_val    : reset contents of register idx, (2 << idx) truncated to width
//   - rf_idx_in_range : true when an index names an existing register
package reg_file_pkg;

    localparam int RF_MAX_REGS = 32;
    localparam int RF_IDX_W    = $clog2(RF_MAX_REGS);

    typedef logic [RF_IDX_W-1:0] reg_idx_t;

    function automatic logic [63:0] rf_reset_val(input int unsigned idx,
                                                 input int unsigned width);
        logic [63:0] val;
        val = 64'd2 << idx;
        if (width < 64) begin
            val = val & ((64'd1 << width) - 64'd1);
        end
        return val;
    endfunction

    // Compared at 32 bits so that NUM_REGS == RF_MAX_REGS does not wrap.
    function automatic logic rf_idx_in_range(input reg_idx_t    idx,
                                             input int unsigned num_regs);
        return 32'(idx) < num_regs;
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard
//   Per-register pending tracker used by issue logic to spot read-after-write
//   hazards on registers whose producing op is still in flight.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     rd_addr_a/b           read addresses whose hazard status is reported
//     wr_en, wr_addr        register write (retires the op on wr_addr)
//     issue_en, issue_addr  new op issued with destination issue_addr
//     hazard_a/b            read address pending and not satisfied this cycle
//     pending               registered pending bit per register
//     issue_err             registered one-cycle pulse for a rejected issue
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int BYPASS   = 1,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [AW-1:0]       rd_addr_a,
    input  logic [AW-1:0]       rd_addr_b,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_addr,
    output logic                hazard_a,
    output logic                hazard_b,
    output logic [NUM_REGS-1:0] pending,
    output logic                issue_err
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic                issue_err_q;
    logic                issue_err_d;

    logic [NUM_REGS-1:0] wr_hit;
    logic                issue_in_range;
    logic                issue_busy;
    logic                issue_ok;
    reg_idx_t            issue_idx;

    // One-hot of the register being written; out-of-range writes hit nothing.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_hit[i] = wr_en && (wr_addr == AW'(i));
        end
    end

    // An issue is accepted when the destination exists and is either idle or
    // being retired by a write in this same cycle.
    always_comb begin
        issue_idx      = reg_idx_t'(issue_addr);
        issue_in_range = rf_idx_in_range(issue_idx, NUM_REGS);
        issue_busy     = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (issue_addr == AW'(i)) begin
                issue_busy = pending_q[i] && !wr_hit[i];
            end
        end
        issue_ok = issue_en && issue_in_range && !issue_busy;
    end

    // Clear on write first, then set on accepted issue so set wins a tie.
    always_comb begin
        pending_d = pending_q & ~wr_hit;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (issue_ok && (issue_addr == AW'(i))) begin
                pending_d[i] = 1'b1;
            end
        end
        issue_err_d = issue_en && !issue_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            issue_err_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            issue_err_q <= issue_err_d;
        end
    end

    // Hazard looks only at registered pending state and the current write,
    // never at issue_en, so it cannot loop back through issue logic.
    always_comb begin
        hazard_a = 1'b0;
        hazard_b = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr_a == AW'(i)) begin
                hazard_a = pending_q[i] && !((BYPASS != 0) && wr_hit[i]);
            end
            if (rd_addr_b == AW'(i)) begin
                hazard_b = pending_q[i] && !((BYPASS != 0) && wr_hit[i]);
            end
        end
    end

    assign pending   = pending_q;
    assign issue_err = issue_err_q;

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb
//   Parametrised general-purpose register file with two combinational read
//   ports, one binary-addressed write port, optional write-to-read bypass and
//   a pending scoreboard for read-after-write hazard detection.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     rd_addr_a/b           read addresses; rd_data_a/b combinational data
//     wr_en, wr_addr,
//     wr_data               write port, registered at the rising edge
//     issue_en, issue_addr  destination of a newly issued op
//     hazard_a/b            read address has an unresolved in-flight writer
//     pending               scoreboard bit per register
//     issue_err             one-cycle pulse after a rejected issue
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4,
    parameter int BYPASS   = 1,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [AW-1:0]       rd_addr_a,
    output logic [WIDTH-1:0]    rd_data_a,
    input  logic [AW-1:0]       rd_addr_b,
    output logic [WIDTH-1:0]    rd_data_b,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_addr,
    output logic                hazard_a,
    output logic                hazard_b,
    output logic [NUM_REGS-1:0] pending,
    output logic                issue_err
);

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];

    logic             wr_in_range;
    logic [WIDTH-1:0] rd_raw_a;
    logic [WIDTH-1:0] rd_raw_b;

    // Write decode; an address past NUM_REGS matches no entry and is dropped.
    always_comb begin
        regs_d      = regs_q;
        wr_in_range = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_addr == AW'(i)) begin
                wr_in_range = 1'b1;
                if (wr_en) begin
                    regs_d[i] = wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= WIDTH'(rf_reset_val(i, WIDTH));
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read muxes built as compare loops so unused address codes read as 0.
    always_comb begin
        rd_raw_a = '0;
        rd_raw_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr_a == AW'(i)) begin
                rd_raw_a = regs_q[i];
            end
            if (rd_addr_b == AW'(i)) begin
                rd_raw_b = regs_q[i];
            end
        end
    end

    // Forward the in-flight write to a same-address read on either port.
    always_comb begin
        rd_data_a = rd_raw_a;
        rd_data_b = rd_raw_b;
        if ((BYPASS != 0) && wr_en && wr_in_range) begin
            if (wr_addr == rd_addr_a) begin
                rd_data_a = wr_data;
            end
            if (wr_addr == rd_addr_b) begin
                rd_data_b = wr_data;
            end
        end
    end

    reg_file_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .BYPASS   (BYPASS),
        .AW       (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .hazard_a   (hazard_a),
        .hazard_b   (hazard_b),
        .pending    (pending),
        .issue_err  (issue_err)
    );

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised general-purpose register file for the CPU datapath; successor to the fixed 4 x 8-bit register block.
- Binary-addressed write port replaces the one-hot write enable.
- Two asynchronous read ports, optional write-to-read bypass, and a per-register pending scoreboard.
- The scoreboard lets issue logic detect read-after-write hazards on in-flight destination registers.

Parameters:
- WIDTH, 8, register data width in bits (>= 2).
- NUM_REGS, 4, number of registers (2..32; need not be a power of two).
- BYPASS, 1, 1 = write data forwarded to a same-cycle read of the same address; 0 = no forwarding.
- AW, $clog2(NUM_REGS), address width (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- rd_addr_a  in  AW  read port A address.
- rd_data_a  out  WIDTH  read port A data (combinational).
- rd_addr_b  in  AW  read port B address.
- rd_data_b  out  WIDTH  read port B data (combinational).
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data.
- issue_en  in  1  mark issue_addr pending (op in flight).
- issue_addr  in  AW  destination register of the issued op.
- hazard_a  out  1  rd_addr_a pending and not resolved this cycle.
- hazard_b  out  1  rd_addr_b pending and not resolved this cycle.
- pending  out  NUM_REGS  scoreboard bit per register.
- issue_err  out  1  registered one-cycle pulse: issue rejected.

Behaviour:
- Reset (rst_n low, asynchronous):
  - reg[i] = (2 << i) truncated to WIDTH, giving 2, 4, 8, 16 at defaults.
  - pending = 0; issue_err = 0.
  - Reset takes priority over every in-flight write or issue; pending ops are forgotten.
- Write: if wr_en and wr_addr < NUM_REGS, reg[wr_addr] <= wr_data at the next edge.
  - Visible on rd_data the cycle after the edge.
  - Out-of-range wr_addr: write ignored, no other effect.
- Read: rd_data_x = reg[rd_addr_x], combinational.
  - Out-of-range address returns 0.
- Bypass (BYPASS=1): if wr_en and wr_addr == rd_addr_x (in range), rd_data_x = wr_data in the same cycle.
  - Both read ports bypass independently.
  - BYPASS=0: rd_data_x shows the old value until after the edge.
- Scoreboard, next-state per register i:
  - wr_en to i clears pending[i].
  - Accepted issue to i sets pending[i].
  - Set wins over clear when both hit the same register in the same cycle: the write retires the old op and the new op is now in flight.
  - A write to a non-pending register is legal; pending is unchanged.
- Issue acceptance: accepted iff issue_addr < NUM_REGS and (pending[issue_addr] == 0 or (wr_en and wr_addr == issue_addr)).
  - Otherwise rejected: no state change, and issue_err = 1 for exactly one cycle after the edge.
- Hazard:
  - hazard_x = pending[rd_addr_x] and not (BYPASS and wr_en and wr_addr == rd_addr_x).
  - Out-of-range rd_addr gives hazard 0.
  - Combinational; must not depend on issue_en in the same cycle.
- All outputs are glitch-tolerant combinational, except pending and issue_err, which are registers.

Decomposition:
- Shared package reg_file_pkg:
  - Function rf_reset_val(idx, width).
  - Constant for the max NUM_REGS.
  - Typedef for the register-index type, used by decode/issue logic.
- One sub-module: reg_file_scoreboard (pending vector, issue acceptance, issue_err, hazard outputs).
  - Parameters NUM_REGS and BYPASS.
  - Storage array and read muxes stay in reg_file_sb.

Test Plan:
- Reset values: assert rst_n low mid-cycle with wr_en=1 active -> immediately rd_data of regs 0..3 = 2, 4, 8, 16; pending = 4'b0000; write not performed.
- Bypass: BYPASS=1, wr_en=1, wr_addr=2, wr_data=8'hA5, rd_addr_a=2 -> rd_data_a = 8'hA5 in the same cycle. With BYPASS=0 -> 8 that cycle, 8'hA5 after the edge.
- Scoreboard RAW: issue reg1 -> pending=4'b0010; next cycle rd_addr_b=1 -> hazard_b=1. Then wr_en to 1 with BYPASS=1 -> hazard_b=0 that cycle, pending=0 after the edge.
- Double issue: issue reg3 twice on consecutive cycles with no write -> second rejected, issue_err high for 1 cycle, pending[3] stays 1.
- Simultaneous retire+issue: pending[0]=1, wr_en to 0 and issue_en to 0 in the same cycle -> accepted, issue_err=0, pending[0]=1, reg0 = wr_data.
- Non-power-of-two: NUM_REGS=5, write to addr 6 and read addr 7 -> no register changes, rd_data=0, hazard=0; issue to 6 -> issue_err pulse.
